// File: rtl/hdmi_timing.sv
// Parametrised CEA-861 progressive timing generator with data-island scheduling.
// Every output is registered and describes the pixel (cx, cy) shown in the same cycle.
module hdmi_timing #(
  parameter int BIT_WIDTH        = 11,
  parameter int BIT_HEIGHT       = 10,
  parameter int FRAME_WIDTH      = 800,
  parameter int FRAME_HEIGHT     = 525,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480,
  parameter int HSYNC_START      = 16,
  parameter int HSYNC_PULSE      = 96,
  parameter int VSYNC_START      = 0,
  parameter int VSYNC_PULSE      = 2,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter bit DATA_ISLAND_EN   = 1'b1,
  parameter int DI_START         = 64,
  parameter int MAX_PACKETS      = 2
) (
  input  logic                  clk_pixel,
  input  logic                  reset_n,
  input  logic                  packet_pending,
  output logic [BIT_WIDTH:0]    cx,
  output logic [BIT_HEIGHT:0]   cy,
  output logic                  hsync,
  output logic                  vsync,
  output logic [2:0]            mode,
  output logic [3:0]            ctrl,
  output logic                  packet_accept,
  output logic [4:0]            packet_slot,
  output logic                  frame_start
);

  localparam int XW         = BIT_WIDTH + 1;
  localparam int YW         = BIT_HEIGHT + 1;
  localparam int START_X    = FRAME_WIDTH - SCREEN_WIDTH;
  localparam int START_Y    = FRAME_HEIGHT - SCREEN_HEIGHT;
  localparam int ISLAND_END = DI_START + 32'sd12 + 32'sd32 * MAX_PACKETS;

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 32'sd1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 32'sd1);
  localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
  localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);
  localparam logic [XW-1:0] X_DI   = XW'(DI_START - 32'sd1);
  localparam logic [4:0]    MAX_PK = 5'(MAX_PACKETS);

  localparam logic [31:0] HS_LO   = 32'(HSYNC_START);
  localparam logic [31:0] HS_HI   = 32'(HSYNC_START + HSYNC_PULSE);
  localparam logic [31:0] VS_LO   = 32'(VSYNC_START);
  localparam logic [31:0] VS_HI   = 32'(VSYNC_START + VSYNC_PULSE);
  localparam logic [31:0] SX      = 32'(START_X);
  localparam logic [31:0] SY      = 32'(START_Y);
  localparam logic [31:0] VG_LO   = 32'(START_X - 32'sd2);
  localparam logic [31:0] VP_LO   = 32'(START_X - 32'sd10);
  localparam logic [31:0] VP_HI   = 32'(START_X - 32'sd3);

  if (ISLAND_END > START_X - 32'sd10) begin : g_chk_fit
    $fatal(1, "hdmi_timing: data island overlaps the video preamble");
  end
  if (DI_START < 32'sd1) begin : g_chk_di
    $fatal(1, "hdmi_timing: DI_START must be at least 1");
  end
  if (MAX_PACKETS < 32'sd1 || MAX_PACKETS > 32'sd18) begin : g_chk_pk
    $fatal(1, "hdmi_timing: MAX_PACKETS out of range 1..18");
  end
  if (FRAME_WIDTH > 32'sd2 ** XW) begin : g_chk_w
    $fatal(1, "hdmi_timing: FRAME_WIDTH does not fit in cx");
  end
  if (FRAME_HEIGHT > 32'sd2 ** YW) begin : g_chk_h
    $fatal(1, "hdmi_timing: FRAME_HEIGHT does not fit in cy");
  end

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_PREAMBLE    = 3'd1,
    ST_LEAD_GUARD  = 3'd2,
    ST_PACKET      = 3'd3,
    ST_TRAIL_GUARD = 3'd4
  } island_state_t;

  // st_r is the island state of the pixel about to be loaded (cx_nx_s).
  island_state_t st_r, st_nx_s;
  logic [4:0]    cnt_r, cnt_nx_s;
  logic [4:0]    npkt_r, npkt_nx_s;
  logic          accept_nx_s;

  logic [XW-1:0] cx_r, cx_nx_s;
  logic [YW-1:0] cy_r, cy_nx_s;
  logic [31:0]   x_s, y_s;
  logic          video_line_s;
  logic          hsync_r, vsync_r, hsync_nx_s, vsync_nx_s;
  logic [2:0]    mode_r, mode_nx_s;
  logic [3:0]    ctrl_r, ctrl_nx_s;
  logic          accept_r;
  logic [4:0]    slot_r, slot_nx_s;
  logic          frame_start_r, frame_start_nx_s;

  // Next pixel position
  always_comb begin
    cx_nx_s = cx_r + X_ONE;
    cy_nx_s = cy_r;
    if (cx_r == X_LAST) begin
      cx_nx_s = '0;
      if (cy_r == Y_LAST) begin
        cy_nx_s = '0;
      end else begin
        cy_nx_s = cy_r + Y_ONE;
      end
    end else begin
      cx_nx_s = cx_r + X_ONE;
    end
  end

  // Island sequencer next state and accept decision
  always_comb begin
    st_nx_s     = st_r;
    cnt_nx_s    = cnt_r;
    npkt_nx_s   = npkt_r;
    accept_nx_s = 1'b0;
    case (st_r)
      ST_IDLE: begin
        cnt_nx_s = 5'd0;
        if (DATA_ISLAND_EN && (cx_nx_s == X_DI) && packet_pending) begin
          accept_nx_s = 1'b1;
          st_nx_s     = ST_PREAMBLE;
          npkt_nx_s   = 5'd1;
        end else begin
          st_nx_s   = ST_IDLE;
          npkt_nx_s = 5'd0;
        end
      end
      ST_PREAMBLE: begin
        if (cnt_r == 5'd7) begin
          st_nx_s  = ST_LEAD_GUARD;
          cnt_nx_s = 5'd0;
        end else begin
          cnt_nx_s = cnt_r + 5'd1;
        end
      end
      ST_LEAD_GUARD: begin
        if (cnt_r == 5'd1) begin
          st_nx_s  = ST_PACKET;
          cnt_nx_s = 5'd0;
        end else begin
          cnt_nx_s = cnt_r + 5'd1;
        end
      end
      ST_PACKET: begin
        if (cnt_r == 5'd31) begin
          cnt_nx_s = 5'd0;
          if (packet_pending && (npkt_r < MAX_PK)) begin
            accept_nx_s = 1'b1;
            npkt_nx_s   = npkt_r + 5'd1;
          end else begin
            st_nx_s = ST_TRAIL_GUARD;
          end
        end else begin
          cnt_nx_s = cnt_r + 5'd1;
        end
      end
      ST_TRAIL_GUARD: begin
        if (cnt_r == 5'd1) begin
          st_nx_s  = ST_IDLE;
          cnt_nx_s = 5'd0;
        end else begin
          cnt_nx_s = cnt_r + 5'd1;
        end
      end
      default: begin
        st_nx_s  = ST_IDLE;
        cnt_nx_s = 5'd0;
      end
    endcase
  end

  // Decode of the pixel about to be shown; video periods win over island periods
  always_comb begin
    x_s              = 32'(cx_nx_s);
    y_s              = 32'(cy_nx_s);
    video_line_s     = (y_s >= SY);
    mode_nx_s        = 3'd0;
    ctrl_nx_s        = 4'b0000;
    slot_nx_s        = 5'd0;
    hsync_nx_s       = ((x_s >= HS_LO) && (x_s < HS_HI)) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
    vsync_nx_s       = ((y_s >= VS_LO) && (y_s < VS_HI)) ? SYNC_ACTIVE_HIGH : ~SYNC_ACTIVE_HIGH;
    frame_start_nx_s = (cx_nx_s == '0) && (cy_nx_s == '0);
    if (video_line_s && (x_s >= SX)) begin
      mode_nx_s = 3'd1;
    end else if (video_line_s && (x_s >= VG_LO)) begin
      mode_nx_s = 3'd2;
    end else if (video_line_s && (x_s >= VP_LO) && (x_s <= VP_HI)) begin
      ctrl_nx_s = 4'b0001;
    end else begin
      case (st_r)
        ST_PREAMBLE:    ctrl_nx_s = 4'b0101;
        ST_LEAD_GUARD:  mode_nx_s = 3'd4;
        ST_TRAIL_GUARD: mode_nx_s = 3'd4;
        ST_PACKET: begin
          mode_nx_s = 3'd3;
          slot_nx_s = cnt_r;
        end
        default:        mode_nx_s = 3'd0;
      endcase
    end
  end

  // Island state register; reset aborts any island in flight
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      st_r   <= ST_IDLE;
      cnt_r  <= 5'd0;
      npkt_r <= 5'd0;
    end else begin
      st_r   <= st_nx_s;
      cnt_r  <= cnt_nx_s;
      npkt_r <= npkt_nx_s;
    end
  end

  // Counters and registered output decode
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      cx_r          <= '0;
      cy_r          <= '0;
      hsync_r       <= ~SYNC_ACTIVE_HIGH;
      vsync_r       <= ~SYNC_ACTIVE_HIGH;
      mode_r        <= 3'd0;
      ctrl_r        <= 4'b0000;
      accept_r      <= 1'b0;
      slot_r        <= 5'd0;
      frame_start_r <= 1'b0;
    end else begin
      cx_r          <= cx_nx_s;
      cy_r          <= cy_nx_s;
      hsync_r       <= hsync_nx_s;
      vsync_r       <= vsync_nx_s;
      mode_r        <= mode_nx_s;
      ctrl_r        <= ctrl_nx_s;
      accept_r      <= accept_nx_s;
      slot_r        <= slot_nx_s;
      frame_start_r <= frame_start_nx_s;
    end
  end

  assign cx            = cx_r;
  assign cy            = cy_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign mode          = mode_r;
  assign ctrl          = ctrl_r;
  assign packet_accept = accept_r;
  assign packet_slot   = slot_r;
  assign frame_start   = frame_start_r;

endmodule

// File: tb/tb_hdmi_timing.sv
// Bench for hdmi_timing: three builds (default, inverted sync without islands, small frame)
// driven by one random packet_pending stream and compared against a pixel-arithmetic model.
module tb_hdmi_timing;

  localparam int NI = 3;
  localparam int FW   [NI] = '{800, 800, 240};
  localparam int FH   [NI] = '{525, 525, 20};
  localparam int SW   [NI] = '{640, 640, 100};
  localparam int SH   [NI] = '{480, 480, 12};
  localparam int HS   [NI] = '{16, 16, 4};
  localparam int HP   [NI] = '{96, 96, 10};
  localparam int VS   [NI] = '{0, 0, 2};
  localparam int VP   [NI] = '{2, 2, 3};
  localparam int POL  [NI] = '{0, 1, 0};
  localparam int EN   [NI] = '{1, 0, 1};
  localparam int DIS  [NI] = '{64, 64, 20};
  localparam int MAXP [NI] = '{2, 2, 3};

  logic clk_pixel = 1'b0;
  logic reset_n;
  logic packet_pending;

  logic [11:0] cx_o  [NI];
  logic [10:0] cy_o  [NI];
  logic        hs_o  [NI];
  logic        vs_o  [NI];
  logic [2:0]  md_o  [NI];
  logic [3:0]  ct_o  [NI];
  logic        acc_o [NI];
  logic [4:0]  sl_o  [NI];
  logic        fs_o  [NI];

  int n_chk = 0;
  int n_err = 0;

  // model state and expected outputs per instance
  int m_cx [NI];
  int m_cy [NI];
  int npk  [NI];
  bit isl_on [NI];
  int e_hs [NI], e_vs [NI], e_md [NI], e_ct [NI], e_acc [NI], e_sl [NI], e_fs [NI];

  always #5 clk_pixel = ~clk_pixel;

  hdmi_timing u_dflt (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_pending(packet_pending),
    .cx(cx_o[0]), .cy(cy_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .mode(md_o[0]),
    .ctrl(ct_o[0]), .packet_accept(acc_o[0]), .packet_slot(sl_o[0]), .frame_start(fs_o[0])
  );

  hdmi_timing #(.SYNC_ACTIVE_HIGH(1'b1), .DATA_ISLAND_EN(1'b0)) u_inv (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_pending(packet_pending),
    .cx(cx_o[1]), .cy(cy_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .mode(md_o[1]),
    .ctrl(ct_o[1]), .packet_accept(acc_o[1]), .packet_slot(sl_o[1]), .frame_start(fs_o[1])
  );

  hdmi_timing #(
    .FRAME_WIDTH(240), .FRAME_HEIGHT(20), .SCREEN_WIDTH(100), .SCREEN_HEIGHT(12),
    .HSYNC_START(4), .HSYNC_PULSE(10), .VSYNC_START(2), .VSYNC_PULSE(3),
    .DI_START(20), .MAX_PACKETS(3)
  ) u_small (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .packet_pending(packet_pending),
    .cx(cx_o[2]), .cy(cy_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .mode(md_o[2]),
    .ctrl(ct_o[2]), .packet_accept(acc_o[2]), .packet_slot(sl_o[2]), .frame_start(fs_o[2])
  );

  // Advance the reference by one clock edge, given reset and packet_pending at that edge.
  task automatic model_edge(input bit rst_low, input bit pend);
    int x, y, sx, sy, off, p;
    for (int k = 0; k < NI; k++) begin
      e_md[k] = 0; e_ct[k] = 0; e_acc[k] = 0; e_sl[k] = 0; e_fs[k] = 0;
      if (rst_low) begin
        m_cx[k] = 0; m_cy[k] = 0; isl_on[k] = 1'b0; npk[k] = 0;
        e_hs[k] = 1 - POL[k];
        e_vs[k] = 1 - POL[k];
      end else begin
        m_cx[k] = m_cx[k] + 1;
        if (m_cx[k] == FW[k]) begin
          m_cx[k] = 0;
          m_cy[k] = (m_cy[k] + 1) % FH[k];
        end
        x = m_cx[k]; y = m_cy[k];
        sx = FW[k] - SW[k]; sy = FH[k] - SH[k];
        e_hs[k] = (x >= HS[k] && x < HS[k] + HP[k]) ? POL[k] : 1 - POL[k];
        e_vs[k] = (y >= VS[k] && y < VS[k] + VP[k]) ? POL[k] : 1 - POL[k];
        e_fs[k] = (x == 0 && y == 0) ? 1 : 0;
        if (y >= sy) begin
          if (x >= sx) e_md[k] = 1;
          else if (x >= sx - 2) e_md[k] = 2;
          else if (x >= sx - 10 && x <= sx - 3) e_ct[k] = 1;
        end
        if (x == DIS[k] - 1) begin
          isl_on[k] = (EN[k] != 0) && pend;
          npk[k] = isl_on[k] ? 1 : 0;
          e_acc[k] = isl_on[k] ? 1 : 0;
        end else if (isl_on[k] && x >= DIS[k]) begin
          off = x - DIS[k];
          if (off < 8) e_ct[k] = 5;
          else if (off < 10) e_md[k] = 4;
          else begin
            p = off - 10;
            if (p < 32 * npk[k]) begin
              e_md[k] = 3;
              e_sl[k] = p % 32;
              if (p % 32 == 31 && p / 32 == npk[k] - 1 && pend && npk[k] < MAXP[k]) begin
                e_acc[k] = 1;
                npk[k] = npk[k] + 1;
              end
            end else if (p < 32 * npk[k] + 2) begin
              e_md[k] = 4;
            end
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d at model cx=%0d cy=%0d",
             tag, k, got, exp, m_cx[k], m_cy[k]);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk("cx", k, 32'(cx_o[k]), 32'(m_cx[k]));
      chk("cy", k, 32'(cy_o[k]), 32'(m_cy[k]));
      chk("hsync", k, 32'(hs_o[k]), 32'(e_hs[k]));
      chk("vsync", k, 32'(vs_o[k]), 32'(e_vs[k]));
      chk("mode", k, 32'(md_o[k]), 32'(e_md[k]));
      chk("ctrl", k, 32'(ct_o[k]), 32'(e_ct[k]));
      chk("accept", k, 32'(acc_o[k]), 32'(e_acc[k]));
      chk("slot", k, 32'(sl_o[k]), 32'(e_sl[k]));
      chk("frame_start", k, 32'(fs_o[k]), 32'(e_fs[k]));
    end
  endtask

  task automatic step(input logic rst_v, input logic pend_v);
    reset_n = rst_v;
    packet_pending = pend_v;
    @(posedge clk_pixel);
    model_edge(!rst_v, pend_v);
    @(negedge clk_pixel);
    check_all();
  endtask

  initial begin
    reset_n = 1'b0;
    packet_pending = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)));

    // lines 0..9: fully random pending
    while (m_cy[0] < 10) step(1'b1, 1'($urandom_range(0, 1)));
    // line 10: single packet, pending dropped one cycle after the accept
    while (m_cy[0] == 10) step(1'b1, (m_cx[0] >= 58 && m_cx[0] <= 63));
    // lines 11..12: back-to-back packets
    while (m_cy[0] < 13) step(1'b1, 1'b1);
    // lines 13..46: random, biased towards pending
    while (m_cy[0] < 47) step(1'b1, ($urandom_range(0, 3) != 0));
    // line 47: island in flight, reset while cx=90 is shown
    while (!(m_cy[0] == 47 && m_cx[0] == 90)) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    while (m_cy[0] < 2) step(1'b1, ($urandom_range(0, 1) != 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
